// File: rtl/ahb2apb_mslv_bridge_pkg.sv
// Shared types, constants and helpers for the multi-slave AHB-Lite to APB bridge.
// State codes are one-hot so each state decodes from a single flop.
package ahb2apb_pkg;

    typedef enum logic [5:0] {
        ST_IDLE   = 6'b000001,
        ST_WAIT   = 6'b000010,
        ST_SETUP  = 6'b000100,
        ST_ACCESS = 6'b001000,
        ST_ERR1   = 6'b010000,
        ST_ERR2   = 6'b100000
    } state_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    function automatic int calc_sel_w(input int num_slv);
        return (num_slv <= 1) ? 1 : $clog2(num_slv);
    endfunction

    // Transfers wider than a word, or not naturally aligned, cannot map onto APB strobes.
    function automatic logic size_ok(input logic [2:0] hsize, input logic [1:0] lane);
        case (hsize)
            HSIZE_BYTE: return 1'b1;
            HSIZE_HALF: return ~lane[0];
            HSIZE_WORD: return (lane == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] calc_pstrb(input logic hwrite, input logic [2:0] hsize,
                                              input logic [1:0] lane);
        logic [3:0] strb;
        strb = 4'b0000;
        if (hwrite) begin
            case (hsize)
                HSIZE_BYTE: strb = 4'b0001 << lane;
                HSIZE_HALF: strb = lane[1] ? 4'b1100 : 4'b0011;
                HSIZE_WORD: strb = 4'b1111;
                default:    strb = 4'b0000;
            endcase
        end
        return strb;
    endfunction

endpackage

// File: rtl/ahb2apb_mslv_bridge_apb_rsp_mux.sv
// Selects pready, pslverr and prdata of the addressed APB slave.
// Out-of-range indices never reach here; they are rejected at request time.
module apb_rsp_mux #(
    parameter int NUM_SLV = 8,
    parameter int SEL_W   = 3
) (
    input  logic [SEL_W-1:0]      sel_idx,
    input  logic [NUM_SLV-1:0]    pready_bus,
    input  logic [NUM_SLV-1:0]    pslverr_bus,
    input  logic [NUM_SLV*32-1:0] prdata_bus,
    output logic                  pready,
    output logic                  pslverr,
    output logic [31:0]           prdata
);

    logic [NUM_SLV-1:0] hit;
    logic [31:0]        masked_rdata [NUM_SLV];

    for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
        assign hit[gi]          = (int'(sel_idx) == gi);
        assign masked_rdata[gi] = hit[gi] ? prdata_bus[gi*32 +: 32] : 32'h0;
    end

    always_comb begin
        prdata = 32'h0;
        for (int i = 0; i < NUM_SLV; i++) begin
            prdata = prdata | masked_rdata[i];
        end
    end

    assign pready  = |(pready_bus & hit);
    assign pslverr = |(pslverr_bus & hit);

endmodule

// File: rtl/ahb2apb_mslv_bridge.sv
// AHB-Lite slave to multi-slave APB bridge with decode, alignment and PREADY-timeout errors.
// APB timing advances only on i_pclk_en ticks; AHB handshake runs at full hclk rate.
module ahb2apb_mslv_bridge
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 8,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 255
) (
    input  logic                  i_hclk,
    input  logic                  i_hrst_n,
    input  logic                  i_pclk_en,
    input  logic                  i_hsel,
    input  logic                  i_hreadyin,
    input  logic                  i_hwrite,
    input  logic                  i_hsec,
    input  logic [1:0]            i_htrans,
    input  logic [2:0]            i_hsize,
    input  logic [3:0]            i_hprot,
    input  logic [ADDR_W-1:0]     i_haddr,
    input  logic [31:0]           i_hwdata,
    output logic                  o_hreadyout,
    output logic [1:0]            o_hresp,
    output logic [31:0]           o_hrdata,
    output logic [NUM_SLV-1:0]    o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_W-1:0]     o_paddr,
    output logic [31:0]           o_pwdata,
    output logic [3:0]            o_pstrb,
    output logic [2:0]            o_pprot,
    input  logic [NUM_SLV-1:0]    i_pready,
    input  logic [NUM_SLV-1:0]    i_pslverr,
    input  logic [NUM_SLV*32-1:0] i_prdata
);

    localparam int                 SEL_W       = calc_sel_w(NUM_SLV);
    localparam bit                 TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [7:0]         TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [NUM_SLV-1:0] PSEL_ONE    = NUM_SLV'(1);

    state_t              state_reg;
    logic [7:0]          cnt_reg;
    logic                wait_first_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                write_reg;
    logic [2:0]          prot_reg;
    logic [3:0]          strb_reg;
    logic [SEL_W-1:0]    idx_reg;
    logic                hreadyout_reg;
    logic [1:0]          hresp_reg;
    logic [31:0]         hrdata_reg;
    logic [NUM_SLV-1:0]  psel_reg;
    logic                penable_reg;
    logic                pwrite_reg;
    logic [ADDR_W-1:0]   paddr_reg;
    logic [31:0]         pwdata_reg;
    logic [3:0]          pstrb_reg;
    logic [2:0]          pprot_reg;

    logic                req;
    logic [SEL_W-1:0]    idx_in;
    logic                idx_ok;
    logic                req_ok;
    logic                mux_pready;
    logic                mux_pslverr;
    logic [31:0]         mux_prdata;
    logic                unused_inputs;

    assign req     = i_hsel & i_htrans[1] & i_hreadyin & hreadyout_reg;
    assign idx_in  = i_haddr[SEL_LSB +: SEL_W];
    assign idx_ok  = (int'(idx_in) < NUM_SLV);
    assign req_ok  = idx_ok & size_ok(i_hsize, i_haddr[1:0]);

    // SEQ vs NONSEQ and the cacheable/bufferable hprot bits do not affect APB.
    assign unused_inputs = ^{i_htrans[0], i_hprot[3:2]};

    apb_rsp_mux #(
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_rsp_mux (
        .sel_idx     (idx_reg),
        .pready_bus  (i_pready),
        .pslverr_bus (i_pslverr),
        .prdata_bus  (i_prdata),
        .pready      (mux_pready),
        .pslverr     (mux_pslverr),
        .prdata      (mux_prdata)
    );

    always_ff @(posedge i_hclk or negedge i_hrst_n) begin
        if (!i_hrst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 8'h0;
            wait_first_reg <= 1'b0;
            addr_reg       <= '0;
            write_reg      <= 1'b0;
            prot_reg       <= 3'b000;
            strb_reg       <= 4'b0000;
            idx_reg        <= '0;
            hreadyout_reg  <= 1'b1;
            hresp_reg      <= HRESP_OKAY;
            hrdata_reg     <= 32'h0;
            psel_reg       <= '0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= 32'h0;
            pstrb_reg      <= 4'b0000;
            pprot_reg      <= 3'b000;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        hreadyout_reg <= 1'b0;
                        if (req_ok) begin
                            addr_reg       <= i_haddr;
                            write_reg      <= i_hwrite;
                            prot_reg       <= {~i_hprot[0], ~i_hsec, i_hprot[1]};
                            strb_reg       <= calc_pstrb(i_hwrite, i_hsize, i_haddr[1:0]);
                            idx_reg        <= idx_in;
                            wait_first_reg <= 1'b1;
                            state_reg      <= ST_WAIT;
                        end else begin
                            hresp_reg <= HRESP_ERROR;
                            state_reg <= ST_ERR1;
                        end
                    end
                end
                ST_WAIT: begin
                    // hwdata is valid in the first data-phase cycle only.
                    wait_first_reg <= 1'b0;
                    if (wait_first_reg && write_reg) begin
                        pwdata_reg <= i_hwdata;
                    end
                    if (i_pclk_en) begin
                        psel_reg    <= PSEL_ONE << idx_reg;
                        penable_reg <= 1'b0;
                        paddr_reg   <= addr_reg;
                        pwrite_reg  <= write_reg;
                        pstrb_reg   <= strb_reg;
                        pprot_reg   <= prot_reg;
                        cnt_reg     <= 8'h0;
                        state_reg   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (i_pclk_en) begin
                        penable_reg <= 1'b1;
                        state_reg   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (i_pclk_en) begin
                        if (mux_pready) begin
                            psel_reg    <= '0;
                            penable_reg <= 1'b0;
                            if (mux_pslverr) begin
                                hresp_reg <= HRESP_ERROR;
                                state_reg <= ST_ERR1;
                            end else begin
                                if (!write_reg) begin
                                    hrdata_reg <= mux_prdata;
                                end
                                hreadyout_reg <= 1'b1;
                                state_reg     <= ST_IDLE;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 8'd1;
                            if (TIMEOUT_EN && (cnt_reg == TIMEOUT_CNT - 8'd1)) begin
                                psel_reg    <= '0;
                                penable_reg <= 1'b0;
                                hresp_reg   <= HRESP_ERROR;
                                state_reg   <= ST_ERR1;
                            end
                        end
                    end
                end
                ST_ERR1: begin
                    hreadyout_reg <= 1'b1;
                    state_reg     <= ST_ERR2;
                end
                ST_ERR2: begin
                    hresp_reg <= HRESP_OKAY;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_hreadyout = hreadyout_reg;
    assign o_hresp     = hresp_reg;
    assign o_hrdata    = hrdata_reg;
    assign o_psel      = psel_reg;
    assign o_penable   = penable_reg;
    assign o_pwrite    = pwrite_reg;
    assign o_paddr     = paddr_reg;
    assign o_pwdata    = pwdata_reg;
    assign o_pstrb     = pstrb_reg;
    assign o_pprot     = pprot_reg;

endmodule

// File: tb/tb_ahb2apb_mslv_bridge.sv
// Randomised bench for ahb2apb_mslv_bridge: transaction-level slave model and expected outcomes.
// Bridge built with five slaves and a four-tick PREADY timeout.
module tb_ahb2apb_mslv_bridge;

    localparam int NS  = 5;
    localparam int TMO = 4;

    logic            hclk;
    logic            hrst_n;
    logic            pclk_en;
    logic            hsel, hreadyin, hwrite, hsec;
    logic [1:0]      htrans;
    logic [2:0]      hsize;
    logic [3:0]      hprot;
    logic [31:0]     haddr, hwdata;
    logic            hreadyout;
    logic [1:0]      hresp;
    logic [31:0]     hrdata;
    logic [NS-1:0]   psel;
    logic            penable, pwrite;
    logic [31:0]     paddr, pwdata;
    logic [3:0]      pstrb;
    logic [2:0]      pprot;
    logic [NS-1:0]   pready, pslverr;
    logic [NS*32-1:0] prdata;

    int          n_checks;
    int          n_errors;
    int          phase;
    logic [31:0] exp_hrdata;

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    ahb2apb_mslv_bridge #(
        .ADDR_W  (32),
        .NUM_SLV (NS),
        .SEL_LSB (12),
        .TIMEOUT (TMO)
    ) dut (
        .i_hclk      (hclk),
        .i_hrst_n    (hrst_n),
        .i_pclk_en   (pclk_en),
        .i_hsel      (hsel),
        .i_hreadyin  (hreadyin),
        .i_hwrite    (hwrite),
        .i_hsec      (hsec),
        .i_htrans    (htrans),
        .i_hsize     (hsize),
        .i_hprot     (hprot),
        .i_haddr     (haddr),
        .i_hwdata    (hwdata),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .o_psel      (psel),
        .o_penable   (penable),
        .o_pwrite    (pwrite),
        .o_paddr     (paddr),
        .o_pwdata    (pwdata),
        .o_pstrb     (pstrb),
        .o_pprot     (pprot),
        .i_pready    (pready),
        .i_pslverr   (pslverr),
        .i_prdata    (prdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_strb(input logic wr, input logic [2:0] size, input logic [1:0] lane);
        if (!wr)       return 4'b0000;
        if (size == 0) return 4'b0001 << lane;
        if (size == 1) return (lane == 2'd0) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    // Target slave answers with its configured status; the others drive noise.
    task automatic drive_slaves(input int tgt, input logic rdy, input logic err);
        pready  = NS'($urandom);
        pslverr = NS'($urandom);
        if (tgt < NS) begin
            pready[tgt]  = rdy;
            pslverr[tgt] = err;
        end
    endtask

    task automatic do_xfer(input int idx, input logic [1:0] lane, input logic [2:0] size,
                           input logic wr, input logic [31:0] wdata, input logic [3:0] prot,
                           input logic sec, input int waits, input logic err, input int div,
                           input logic [16:0] hi, input logic [9:0] mid);
        logic [31:0] addr;
        logic [31:0] sdata [NS];
        logic        bad, tmo, serr, ok, done, hresp_any;
        logic [1:0]  end_hresp, last_low_hresp;
        logic [45:0] apb_now, apb_prev;
        logic [39:0] ctl_prev;
        logic [NS-1:0] psel_prev, psel_or;
        logic        en_prev, tgt_rdy;
        logic [31:0] cap_paddr, cap_pwdata;
        logic [3:0]  cap_pstrb;
        logic [2:0]  cap_pprot;
        logic        cap_pwrite;
        int          cyc, low, acc, freeze_viol, unstable, proto_viol, exp_low;

        addr = {hi, 3'(idx), mid, lane};
        bad  = (size > 3'd2) || (size == 3'd1 && lane[0]) || (size == 3'd2 && lane != 2'd0) || (idx >= NS);
        tmo  = !bad && (waits >= TMO);
        serr = !bad && !tmo && err;
        ok   = !bad && !tmo && !err;

        @(negedge hclk);
        check_val("hready_idle", 32'(hreadyout), 32'd1);
        for (int k = 0; k < NS; k++) begin
            sdata[k] = $urandom;
            prdata[k*32 +: 32] = sdata[k];
        end
        hsel = 1'b1; htrans = 2'b10; hreadyin = 1'b1;
        haddr = addr; hwrite = wr; hsize = size; hprot = prot; hsec = sec;
        acc = 0;
        phase++;
        pclk_en = ((phase % div) == 0);
        drive_slaves(idx, (acc >= waits), err);

        apb_prev  = {psel, penable, paddr, pstrb, pwrite, pprot};
        psel_prev = psel;
        ctl_prev  = {paddr, pstrb, pwrite, pprot};
        en_prev   = pclk_en;
        psel_or = '0; done = 1'b0; hresp_any = 1'b0; end_hresp = 2'b00; last_low_hresp = 2'b00;
        cap_paddr = 0; cap_pwdata = 0; cap_pstrb = 0; cap_pprot = 0; cap_pwrite = 0;
        cyc = 0; low = 0; freeze_viol = 0; unstable = 0; proto_viol = 0;

        while (!done && cyc < 400) begin
            @(negedge hclk);
            cyc++;
            if (cyc == 1) begin
                hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
            end
            apb_now = {psel, penable, paddr, pstrb, pwrite, pprot};
            if (apb_now != apb_prev && !en_prev) freeze_viol++;
            if (psel != 0 && psel_prev != 0 && {paddr, pstrb, pwrite, pprot} != ctl_prev) unstable++;
            if (psel != 0) begin
                psel_or |= psel;
                if (!$onehot(psel)) proto_viol++;
                cap_paddr = paddr; cap_pwdata = pwdata; cap_pstrb = pstrb;
                cap_pprot = pprot; cap_pwrite = pwrite;
            end
            if (penable && psel == 0) proto_viol++;
            if (hreadyout) begin
                done = 1'b1;
                end_hresp = hresp;
            end else begin
                low++;
                last_low_hresp = hresp;
                if (hresp != 2'b00) hresp_any = 1'b1;
            end
            phase++;
            pclk_en = ((phase % div) == 0);
            tgt_rdy = (acc >= waits);
            drive_slaves(idx, tgt_rdy, err);
            if (pclk_en && penable && !tgt_rdy) acc++;
            apb_prev = apb_now; psel_prev = psel; ctl_prev = {paddr, pstrb, pwrite, pprot};
            en_prev = pclk_en;
        end

        check_val("complete", 32'(done), 32'd1);
        check_val("hresp_end", 32'(end_hresp), ok ? 32'd0 : 32'd1);
        if (ok) check_val("hresp_clean", 32'(hresp_any), 32'd0);
        else    check_val("hresp_err1", 32'(last_low_hresp), 32'd1);
        check_val("psel", 32'(psel_or), bad ? 32'd0 : (32'd1 << idx));
        check_val("apb_freeze", 32'(freeze_viol), 32'd0);
        check_val("apb_hold", 32'(unstable), 32'd0);
        check_val("apb_proto", 32'(proto_viol), 32'd0);
        if (!bad) begin
            check_val("paddr", cap_paddr, addr);
            check_val("pwrite", 32'(cap_pwrite), 32'(wr));
            check_val("pstrb", 32'(cap_pstrb), 32'(exp_strb(wr, size, lane)));
            check_val("pprot", 32'(cap_pprot), 32'({~prot[0], ~sec, prot[1]}));
            check_val("ticks", 32'(acc), tmo ? 32'(TMO) : 32'(waits));
            if (wr) check_val("pwdata", cap_pwdata, wdata);
        end
        if (ok && !wr) exp_hrdata = sdata[idx];
        check_val("hrdata", hrdata, exp_hrdata);
        if (div == 1) begin
            exp_low = bad ? 1 : tmo ? (3 + TMO) : serr ? (4 + waits) : (3 + waits);
            check_val("latency", 32'(low), 32'(exp_low));
        end
        $display("xfer addr=%h wr=%0d size=%0d waits=%0d err=%0d div=%0d -> hresp=%0d wait_cycles=%0d",
                 addr, wr, size, waits, err, div, end_hresp, low);
    endtask

    task automatic reset_mid_access();
        int cyc;
        @(negedge hclk);
        pclk_en = 1'b1; pready = '0; pslverr = '0;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_2008; hwrite = 1'b1; hsize = 3'd2;
        @(negedge hclk);
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
        cyc = 0;
        while (!penable && cyc < 50) begin
            @(negedge hclk);
            cyc++;
        end
        check_val("rst_reach_access", 32'(penable), 32'd1);
        check_val("rst_psel_before", 32'(psel), 32'h4);
        #2 hrst_n = 1'b0;
        #1;
        check_val("rst_psel", 32'(psel), 32'd0);
        check_val("rst_penable", 32'(penable), 32'd0);
        check_val("rst_hresp", 32'(hresp), 32'd0);
        check_val("rst_hready", 32'(hreadyout), 32'd1);
        check_val("rst_paddr", paddr, 32'd0);
        check_val("rst_pwdata", pwdata, 32'd0);
        exp_hrdata = 32'h0;
        $display("xfer reset asserted during ACCESS of slave 2");
        @(negedge hclk);
        hrst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; phase = 0; exp_hrdata = 32'h0;
        hrst_n = 1'b1; pclk_en = 1'b0;
        hsel = 1'b0; hreadyin = 1'b1; hwrite = 1'b0; hsec = 1'b0;
        htrans = 2'b00; hsize = 3'd0; hprot = 4'h0; haddr = 32'h0; hwdata = 32'h0;
        pready = '0; pslverr = '0; prdata = '0;
        #1 hrst_n = 1'b0;
        #1;
        check_val("reset_hready", 32'(hreadyout), 32'd1);
        check_val("reset_hresp", 32'(hresp), 32'd0);
        check_val("reset_hrdata", hrdata, 32'd0);
        check_val("reset_psel", 32'(psel), 32'd0);
        check_val("reset_penable", 32'(penable), 32'd0);
        check_val("reset_paddr", paddr, 32'd0);
        check_val("reset_pstrb", 32'(pstrb), 32'd0);
        check_val("reset_pprot", 32'({pwrite, pprot}), 32'd0);
        @(negedge hclk);
        hrst_n = 1'b1;

        // Word write to slave 3 at 0x3004, zero wait states, pclk_en tied high.
        do_xfer(3, 2'd0, 3'd2, 1'b1, 32'hA5A5_0001, 4'b0011, 1'b0, 0, 1'b0, 1, 17'h0, 10'd1);
        // Half read at 0x1002, pclk every 4th cycle, two wait states.
        do_xfer(1, 2'd2, 3'd1, 1'b0, 32'h0, 4'b0001, 1'b1, 2, 1'b0, 4, 17'h0, 10'd0);
        // Slave 2 signals pslverr.
        do_xfer(2, 2'd0, 3'd2, 1'b1, 32'hDEAD_BEEF, 4'b0010, 1'b0, 1, 1'b1, 1, 17'h0, 10'd3);
        // Index 6 has no slave.
        do_xfer(6, 2'd0, 3'd2, 1'b0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1, 17'h0, 10'd0);
        // Misaligned word and oversize transfer.
        do_xfer(0, 2'd2, 3'd2, 1'b1, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1, 17'h0, 10'd0);
        do_xfer(4, 2'd0, 3'd3, 1'b0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1, 17'h0, 10'd0);
        // Slave never ready, then a clean access.
        do_xfer(0, 2'd0, 3'd2, 1'b0, 32'h0, 4'b0000, 1'b0, 50, 1'b0, 2, 17'h0, 10'd5);
        do_xfer(0, 2'd0, 3'd2, 1'b0, 32'h0, 4'b0000, 1'b0, 0, 1'b0, 1, 17'h0, 10'd5);
        // Reset mid-transfer, then a normal transfer.
        reset_mid_access();
        do_xfer(4, 2'd3, 3'd0, 1'b1, 32'h0BAD_F00D, 4'b1010, 1'b1, 0, 1'b0, 1, 17'h1, 10'd7);
        do_xfer(4, 2'd0, 3'd2, 1'b0, 32'h0, 4'b1010, 1'b1, 1, 1'b0, 1, 17'h1, 10'd7);

        for (int n = 0; n < 60; n++) begin
            int div_sel;
            div_sel = $urandom_range(0, 3);
            do_xfer($urandom_range(0, 7), 2'($urandom), 3'($urandom_range(0, 3)), 1'($urandom),
                    $urandom, 4'($urandom), 1'($urandom), $urandom_range(0, 5),
                    ($urandom_range(0, 5) == 0), (div_sel == 0) ? 1 : (div_sel == 1) ? 2 : (div_sel == 2) ? 3 : 4,
                    17'($urandom), 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
